// File: rtl/ram16k_req_ctrl.sv
// Single-outstanding request sequencer in front of the 16K x 16 RAM.
// Each request gets one ACCESS cycle with stable RAM controls and a held registered response.
module ram16k_req_ctrl #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [15:0]       txn_count,
    output logic [ADDR_W-1:0] ram_add,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_read,
    output logic              ram_write,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_out
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              we_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              req_fire;
    logic              rsp_fire;
    logic              in_access;

    assign req_ready = ~reset & ((state == IDLE) | ((state == RESP) & rsp_ready));
    assign req_fire  = req_valid & req_ready;
    assign rsp_valid = (state == RESP);
    assign rsp_fire  = rsp_valid & rsp_ready;

    // RAM controls come only from state and captured registers; reset gates every strobe
    assign in_access = ~reset & (state == ACCESS);
    assign ram_en    = in_access;
    assign ram_write = in_access & we_p0;
    assign ram_read  = in_access & ~we_p0;
    assign ram_add   = addr_p0;
    assign ram_in    = wdata_p0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = req_fire ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p0: request capture; response and counter update at the end of ACCESS / RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            we_p0     <= 1'b0;
            addr_p0   <= '0;
            wdata_p0  <= '0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
            txn_count <= 16'd0;
        end else begin
            state <= state_nxt;
            if (req_fire) begin
                we_p0    <= req_we;
                addr_p0  <= req_addr;
                wdata_p0 <= req_wdata;
            end
            if (state == ACCESS) begin
                rsp_we    <= we_p0;
                rsp_rdata <= we_p0 ? wdata_p0 : ram_out;
            end
            if (rsp_fire) txn_count <= txn_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_ram16k_req_ctrl.sv
// Bench for ram16k_req_ctrl: behavioural RAM, reference memory model and
// response queue; directed steps followed by randomized traffic.
module tb_ram16k_req_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_we;
    logic [15:0] rsp_rdata;
    logic [15:0] txn_count;
    logic [13:0] ram_add;
    logic [15:0] ram_in;
    logic        ram_read;
    logic        ram_write;
    logic        ram_en;
    logic [15:0] ram_out;

    ram16k_req_ctrl #(.ADDR_W(14), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .txn_count(txn_count),
        .ram_add(ram_add), .ram_in(ram_in), .ram_read(ram_read),
        .ram_write(ram_write), .ram_en(ram_en), .ram_out(ram_out)
    );

    // Behavioural RAM: asynchronous read, write on the rising edge
    logic [15:0] mem [0:16383];
    assign ram_out = (ram_en && ram_read) ? mem[ram_add] : 16'h0000;
    always @(posedge clk) if (ram_en && ram_write) mem[ram_add] <= ram_in;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt;
    logic [15:0] ref_mem [0:16383];
    logic [16:0] exp_q [$];
    logic        s_we [$];
    logic [13:0] s_addr [$];
    logic [15:0] s_data [$];
    logic [13:0] wr_addrs [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: requests take effect in acceptance order; a read sees the latest write
    function automatic logic [15:0] model_apply(input logic we, input logic [13:0] a, input logic [15:0] d);
        if (we) begin
            ref_mem[a] = d;
            return d;
        end
        return ref_mem[a];
    endfunction

    task automatic txn(input logic we, input logic [13:0] addr, input logic [15:0] data, input int stall);
        int          n = 0;
        logic [15:0] exp_d;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; rsp_ready = 1'b1;
        #1;
        while (!req_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("txn_req_ready", 32'(req_ready), 32'd1);
        exp_d = model_apply(we, addr, data);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (stall > 0) rsp_ready = 1'b0;
        chk("access_en", 32'(ram_en), 32'd1);
        chk("access_write", 32'(ram_write), 32'(we));
        chk("access_read", 32'(ram_read), 32'(!we));
        chk("access_add", 32'(ram_add), 32'(addr));
        if (we) chk("access_in", 32'(ram_in), 32'(data));
        chk("access_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("resp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_we", 32'(rsp_we), 32'(we));
        chk("resp_rdata", 32'(rsp_rdata), 32'(exp_d));
        chk("resp_write_low", 32'(ram_write), 32'd0);
        for (int i = 1; i < stall; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = addr ^ 14'h0001; req_wdata = 16'hDEAD;
            @(posedge clk); #1;
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rdata", 32'(rsp_rdata), 32'(exp_d));
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_ram_en", 32'(ram_en), 32'd0);
            chk("stall_count", 32'(txn_count), 32'(exp_cnt));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        chk("txn_count", 32'(txn_count), 32'(exp_cnt));
        chk("rsp_done_valid", 32'(rsp_valid), 32'd0);
    endtask

    task automatic run_stream(input bit rand_rdy, input bit rand_gap, output int first_acc, output int last_rsp);
        int          n;
        int          got = 0;
        int          c = 0;
        bit          acc;
        logic [16:0] e;
        n = s_we.size();
        first_acc = -1;
        last_rsp = -1;
        while (got < n && c < 4000) begin
            @(negedge clk);
            rsp_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (!req_valid && s_we.size() > 0 && !(rand_gap && $urandom_range(0, 3) == 0)) begin
                req_valid = 1'b1;
                req_we    = s_we.pop_front();
                req_addr  = s_addr.pop_front();
                req_wdata = s_data.pop_front();
            end
            #1;
            chk("stream_count", 32'(txn_count), 32'(exp_cnt));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_spurious_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_rsp_we", 32'(rsp_we), 32'(e[16]));
                    chk("stream_rsp_rdata", 32'(rsp_rdata), 32'(e[15:0]));
                end
                got++;
                exp_cnt = exp_cnt + 16'd1;
                last_rsp = c;
            end
            acc = req_valid && req_ready;
            if (acc) begin
                exp_q.push_back({req_we, model_apply(req_we, req_addr, req_wdata)});
                if (first_acc < 0) first_acc = c;
            end
            @(posedge clk); #1;
            if (acc) req_valid = 1'b0;
            c++;
        end
        chk("stream_done", 32'(got), 32'(n));
        req_valid = 1'b0;
        rsp_ready = 1'b1;
    endtask

    initial begin
        int          fa;
        int          lr;
        logic [13:0] a;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; exp_cnt = 16'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_we", 32'(rsp_we), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_count", 32'(txn_count), 32'd0);
        chk("rst_strobes", 32'({ram_en, ram_read, ram_write}), 32'd0);
        chk("rst_ram_add", 32'(ram_add), 32'd0);
        chk("rst_ram_in", 32'(ram_in), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("idle_strobes", 32'({ram_en, ram_read, ram_write}), 32'd0);
        chk("idle_count", 32'(txn_count), 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        // Write then read back
        txn(1'b1, 14'h0000, 16'hBEEF, 0);
        txn(1'b0, 14'h0000, 16'h0000, 0);
        chk("wr_rd_count", 32'(txn_count), 32'd2);
        wr_addrs.push_back(14'h0000);

        // Back-to-back with continuous req_valid
        s_we.push_back(1'b1); s_addr.push_back(14'h3FFF); s_data.push_back(16'h1234);
        s_we.push_back(1'b1); s_addr.push_back(14'h1000); s_data.push_back(16'h5678);
        s_we.push_back(1'b0); s_addr.push_back(14'h3FFF); s_data.push_back(16'h0000);
        s_we.push_back(1'b0); s_addr.push_back(14'h1000); s_data.push_back(16'h0000);
        run_stream(1'b0, 1'b0, fa, lr);
        chk("b2b_span", 32'(lr - fa), 32'd8);
        chk("b2b_count", 32'(txn_count), 32'd6);
        wr_addrs.push_back(14'h3FFF);
        wr_addrs.push_back(14'h1000);

        // Backpressure
        txn(1'b1, 14'h0123, 16'hC0DE, 5);
        txn(1'b0, 14'h0123, 16'h0000, 5);
        wr_addrs.push_back(14'h0123);

        // Reset during the ACCESS cycle of a write
        txn(1'b1, 14'h0010, 16'h5555, 0);
        wr_addrs.push_back(14'h0010);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 14'h0010; req_wdata = 16'hAAAA;
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_write_gated", 32'(ram_write), 32'd0);
        chk("abort_en_gated", 32'(ram_en), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = 16'd0;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_count", 32'(txn_count), 32'd0);
        @(posedge clk); #1;
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        txn(1'b0, 14'h0010, 16'h0000, 0);

        // Randomized traffic with random backpressure and request gaps
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 15)) : 14'($urandom_range(0, 16383));
                s_we.push_back(1'b1); s_addr.push_back(a); s_data.push_back(16'($urandom));
                wr_addrs.push_back(a);
            end else begin
                a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
                s_we.push_back(1'b0); s_addr.push_back(a); s_data.push_back(16'($urandom));
            end
        end
        run_stream(1'b1, 1'b1, fa, lr);

        // Counter wrap from a preloaded value
        @(negedge clk);
        force dut.txn_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.txn_count;
        exp_cnt = 16'hFFFE;
        #1;
        chk("wrap_preload", 32'(txn_count), 32'h0000FFFE);
        txn(1'b1, 14'h0200, 16'h0F0F, 0);
        chk("wrap_ffff", 32'(txn_count), 32'h0000FFFF);
        txn(1'b0, 14'h0200, 16'h0000, 0);
        chk("wrap_zero", 32'(txn_count), 32'h00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
